// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg
// Shared definitions for the system-bus interconnect:
//   region_width() - width of the region-select index for a given slave count
//   state_t        - request tracker states (IDLE / BUSY)
//   RESP_OK/ERR    - values driven on the master error line
package sys_bus_pkg;

  // Width of the region index; NS=1 would give zero, so clamp to one bit
  function automatic int region_width(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/sys_bus_resp_mux.sv
// sys_bus_resp_mux
// Selects the addressed slave's ack/err/rdata and registers the one-cycle
// response back to the master. A locally generated error (unmapped region)
// overrides any slave response.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   sel            - index of the slave currently owning the transaction
//   accept         - a slave ack on sel may be turned into a response now
//   local_err      - answer the master with an error this cycle
//   slv_rdata/err/ack - flattened slave response buses
//   rdata/err/ack  - registered response to the master
module sys_bus_resp_mux
  import sys_bus_pkg::*;
#(
  parameter int DW = 32,
  parameter int NS = 8,
  parameter int SW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW-1:0]    sel,
  input  logic             accept,
  input  logic             local_err,
  input  logic [NS*DW-1:0] slv_rdata,
  input  logic [NS-1:0]    slv_err,
  input  logic [NS-1:0]    slv_ack,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic             ack
);

  logic [DW-1:0] sel_rdata;
  logic          sel_err;
  logic          sel_ack;

  // Indexed NS:1 mux; acks from every other slave are simply not looked at
  assign sel_rdata = slv_rdata[sel*DW +: DW];
  assign sel_err   = slv_err[sel];
  assign sel_ack   = slv_ack[sel];

  // Response register: ack/err are single-cycle pulses, rdata holds between
  // responses so the master can sample it late
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      err   <= RESP_OK;
      ack   <= 1'b0;
    end else if (local_err) begin
      rdata <= '0;
      err   <= RESP_ERR;
      ack   <= 1'b1;
    end else if (accept && sel_ack) begin
      rdata <= sel_rdata;
      err   <= sel_err;
      ack   <= 1'b1;
    end else begin
      err   <= RESP_OK;
      ack   <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_bus_interconnect.sv
// sys_bus_interconnect
// Single-master to NS-slave router for the system bus. The region field
// sys_addr_i[RBIT +: log2(NS)] picks the slave; strobes, address and write
// data are registered one cycle toward the slaves, and the selected slave's
// ack/err/rdata come back as a registered one-cycle response.
// Ports:
//   sys_clk_i, sys_rst_i                      - clock, sync active-high reset
//   sys_addr_i, sys_wdata_i, sys_wen_i, sys_ren_i - master request
//   sys_rdata_o, sys_err_o, sys_ack_o         - master response
//   region_en_i                               - per-region enable (0 = unmapped)
//   sys_addr_o, sys_wdata_o, sys_wen_o, sys_ren_o - slave request (shared addr/data)
//   sys_rdata_i, sys_err_i, sys_ack_i         - slave responses, slave k at [k*DW +: DW]
module sys_bus_interconnect
  import sys_bus_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int NS   = 8,
  parameter int RBIT = 20
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic [AW-1:0]    sys_addr_i,
  input  logic [DW-1:0]    sys_wdata_i,
  input  logic             sys_wen_i,
  input  logic             sys_ren_i,
  output logic [DW-1:0]    sys_rdata_o,
  output logic             sys_err_o,
  output logic             sys_ack_o,
  input  logic [NS-1:0]    region_en_i,
  output logic [AW-1:0]    sys_addr_o,
  output logic [DW-1:0]    sys_wdata_o,
  output logic [NS-1:0]    sys_wen_o,
  output logic [NS-1:0]    sys_ren_o,
  input  logic [NS*DW-1:0] sys_rdata_i,
  input  logic [NS-1:0]    sys_err_i,
  input  logic [NS-1:0]    sys_ack_i
);

  localparam int SW = region_width(NS);

  state_t        state;
  logic [SW-1:0] sel;
  logic [SW-1:0] region;
  logic [NS-1:0] region_onehot;
  logic          req;
  logic          region_ok;
  logic          local_err;
  logic          accept;

  // Decode of the incoming request
  assign req           = sys_wen_i | sys_ren_i;
  assign region        = sys_addr_i[RBIT +: SW];
  assign region_onehot = {{(NS-1){1'b0}}, 1'b1} << region;
  assign region_ok     = region_en_i[region];
  assign local_err     = req & ~region_ok;

  // A new request always wins over a response arriving in the same cycle:
  // the old transaction is abandoned, so its ack must not reach the master
  assign accept = (state == BUSY) & ~req;

  // Request register and transaction tracker. A write beats a simultaneous
  // read. A request to an unmapped region never reaches a slave and leaves
  // the tracker idle, which also abandons anything still pending.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state       <= IDLE;
      sel         <= '0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_wen_o   <= '0;
      sys_ren_o   <= '0;
    end else begin
      sys_wen_o <= '0;
      sys_ren_o <= '0;
      if (req) begin
        sys_addr_o  <= sys_addr_i;
        sys_wdata_o <= sys_wdata_i;
        sel         <= region;
        if (region_ok) begin
          state <= BUSY;
          if (sys_wen_i) sys_wen_o <= region_onehot;
          else           sys_ren_o <= region_onehot;
        end else begin
          state <= IDLE;
        end
      end else if (state == BUSY && sys_ack_i[sel]) begin
        state <= IDLE;
      end
    end
  end

  sys_bus_resp_mux #(
    .DW (DW),
    .NS (NS),
    .SW (SW)
  ) u_resp_mux (
    .clk       (sys_clk_i),
    .rst       (sys_rst_i),
    .sel       (sel),
    .accept    (accept),
    .local_err (local_err),
    .slv_rdata (sys_rdata_i),
    .slv_err   (sys_err_i),
    .slv_ack   (sys_ack_i),
    .rdata     (sys_rdata_o),
    .err       (sys_err_o),
    .ack       (sys_ack_o)
  );

endmodule
